// File: rtl/l2_xwidth_buffer.sv
// rtl/l2_xwidth_buffer.sv - asymmetric-width single-clock L2 staging FIFO (L1 words <-> DDR lines)
// Direction (FILL/DRAIN) is locked from the first accepted write until the buffer empties.
module l2_xwidth_buffer #(
  parameter int L1_W   = 16,
  parameter int DDR_W  = 128,
  parameter int DEPTH  = 4096,
  parameter int AF_LVL = DEPTH - DDR_W / L1_W,
  parameter int AE_LVL = DDR_W / L1_W
) (
  input  logic                   clk_166M66,
  input  logic                   mcu_sys_rst_n,
  input  logic                   i_flush,
  input  logic                   i_l1_wr_en,
  input  logic [L1_W-1:0]        i_l1_wdata,
  output logic                   o_l1_wr_ready,
  input  logic                   i_l1_rd_en,
  output logic                   o_l1_rd_ready,
  output logic [L1_W-1:0]        o_l1_rdata,
  output logic                   o_l1_rvalid,
  input  logic                   i_ddr_wr_en,
  input  logic [DDR_W-1:0]       i_ddr_wdata,
  output logic                   o_ddr_wr_ready,
  input  logic                   i_ddr_rd_en,
  output logic                   o_ddr_rd_ready,
  output logic [DDR_W-1:0]       o_ddr_rdata,
  output logic                   o_ddr_rvalid,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_almost_full,
  output logic                   o_almost_empty,
  output logic [1:0]             o_state,
  output logic                   o_err
);
  localparam int RATIO = DDR_W / L1_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = $clog2(RATIO);
  localparam int LAW   = AW - RW;
  localparam int LINES = DEPTH / RATIO;

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_RATIO = (AW+1)'(RATIO);
  localparam logic [AW:0] C_AF    = (AW+1)'(AF_LVL);
  localparam logic [AW:0] C_AE    = (AW+1)'(AE_LVL);

  typedef enum logic [1:0] {IDLE = 2'b00, FILL = 2'b01, DRAIN = 2'b10} state_t;

  state_t            state, state_nxt;
  logic [AW:0]       l1_ptr, l1_ptr_nxt;
  logic [LAW:0]      ddr_ptr, ddr_ptr_nxt;
  logic [AW:0]       ddr_word_ptr_nxt, fill_diff, drain_diff;
  logic [AW:0]       count, count_nxt;
  logic              acc_ddr_wr, acc_l1_wr, acc_l1_rd, acc_ddr_rd, reject;
  logic [RW-1:0]     l1_lane;
  logic [LAW-1:0]    l1_line, ddr_line;
  logic [DDR_W-1:0]  mem [LINES];

  assign l1_lane  = l1_ptr[RW-1:0];
  assign l1_line  = l1_ptr[AW-1:RW];
  assign ddr_line = ddr_ptr[LAW-1:0];

  // In IDLE a simultaneous DDR write claims the buffer, so the L1 write loses.
  assign acc_ddr_wr = !i_flush && i_ddr_wr_en && o_ddr_wr_ready;
  assign acc_l1_wr  = !i_flush && i_l1_wr_en && o_l1_wr_ready && !(state == IDLE && i_ddr_wr_en);
  assign acc_l1_rd  = !i_flush && i_l1_rd_en && o_l1_rd_ready;
  assign acc_ddr_rd = !i_flush && i_ddr_rd_en && o_ddr_rd_ready;
  assign reject     = !i_flush && ((i_ddr_wr_en && !acc_ddr_wr) || (i_l1_wr_en && !acc_l1_wr) ||
                                   (i_l1_rd_en && !acc_l1_rd)  || (i_ddr_rd_en && !acc_ddr_rd));

  assign l1_ptr_nxt       = l1_ptr + (AW+1)'(acc_l1_wr | acc_l1_rd);
  assign ddr_ptr_nxt      = ddr_ptr + (LAW+1)'(acc_ddr_wr | acc_ddr_rd);
  assign ddr_word_ptr_nxt = {ddr_ptr_nxt, {RW{1'b0}}};
  assign fill_diff        = ddr_word_ptr_nxt - l1_ptr_nxt;
  assign drain_diff       = l1_ptr_nxt - ddr_word_ptr_nxt;

  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc_ddr_wr) state_nxt = FILL;
               else if (acc_l1_wr) state_nxt = DRAIN;
      FILL:    if (fill_diff == '0) state_nxt = IDLE;
      DRAIN:   if (drain_diff == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_flush) state_nxt = IDLE;
  end

  always_comb begin
    count_nxt = '0;
    if (state_nxt == FILL)       count_nxt = fill_diff;
    else if (state_nxt == DRAIN) count_nxt = drain_diff;
  end

  always_comb begin
    o_ddr_wr_ready = (state == IDLE || state == FILL) && (count <= C_DEPTH - C_RATIO);
    o_l1_rd_ready  = (state == FILL) && (count != '0);
    o_l1_wr_ready  = (state == IDLE || state == DRAIN) && (count < C_DEPTH);
    o_ddr_rd_ready = (state == DRAIN) && (count >= C_RATIO);
    o_count        = count;
    o_full         = (count == C_DEPTH);
    o_empty        = (count == '0);
    o_almost_full  = (count >= C_AF);
    o_almost_empty = (count <= C_AE);
    o_state        = state;
  end

  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) begin
      l1_ptr       <= '0;
      ddr_ptr      <= '0;
      count        <= '0;
      o_l1_rdata   <= '0;
      o_l1_rvalid  <= 1'b0;
      o_ddr_rdata  <= '0;
      o_ddr_rvalid <= 1'b0;
      o_err        <= 1'b0;
    end else if (i_flush) begin
      l1_ptr       <= '0;
      ddr_ptr      <= '0;
      count        <= '0;
      o_l1_rdata   <= '0;
      o_l1_rvalid  <= 1'b0;
      o_ddr_rdata  <= '0;
      o_ddr_rvalid <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      l1_ptr       <= l1_ptr_nxt;
      ddr_ptr      <= ddr_ptr_nxt;
      count        <= count_nxt;
      o_l1_rvalid  <= acc_l1_rd;
      o_ddr_rvalid <= acc_ddr_rd;
      o_err        <= reject;
      if (acc_l1_rd)  o_l1_rdata  <= mem[l1_line][l1_lane*L1_W +: L1_W];
      if (acc_ddr_rd) o_ddr_rdata <= mem[ddr_line];
    end
  end

  // Read and write never hit the same line in one cycle, so registered reads return old data.
  always_ff @(posedge clk_166M66) begin
    if (acc_ddr_wr) mem[ddr_line] <= i_ddr_wdata;
    if (acc_l1_wr)  mem[l1_line][l1_lane*L1_W +: L1_W] <= i_l1_wdata;
  end
endmodule

// File: tb/tb_l2_xwidth_buffer.sv
// tb/tb_l2_xwidth_buffer.sv - self-checking bench for l2_xwidth_buffer against a word-queue model
module tb_l2_xwidth_buffer;
  localparam int L1_W  = 16;
  localparam int DDR_W = 128;
  localparam int DEPTH = 32;
  localparam int RATIO = DDR_W / L1_W;
  localparam int AW    = 5;
  localparam int AF    = DEPTH - RATIO;
  localparam int AE    = RATIO;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #3 clk = ~clk;

  logic              flush, l1_wr_en, l1_rd_en, ddr_wr_en, ddr_rd_en;
  logic [L1_W-1:0]   l1_wdata, l1_rdata;
  logic [DDR_W-1:0]  ddr_wdata, ddr_rdata;
  logic              l1_wr_ready, l1_rd_ready, l1_rvalid;
  logic              ddr_wr_ready, ddr_rd_ready, ddr_rvalid;
  logic [AW:0]       count;
  logic              full, empty, almost_full, almost_empty, err;
  logic [1:0]        state;

  l2_xwidth_buffer #(.L1_W(L1_W), .DDR_W(DDR_W), .DEPTH(DEPTH)) dut (
    .clk_166M66(clk), .mcu_sys_rst_n(rst_n), .i_flush(flush),
    .i_l1_wr_en(l1_wr_en), .i_l1_wdata(l1_wdata), .o_l1_wr_ready(l1_wr_ready),
    .i_l1_rd_en(l1_rd_en), .o_l1_rd_ready(l1_rd_ready), .o_l1_rdata(l1_rdata), .o_l1_rvalid(l1_rvalid),
    .i_ddr_wr_en(ddr_wr_en), .i_ddr_wdata(ddr_wdata), .o_ddr_wr_ready(ddr_wr_ready),
    .i_ddr_rd_en(ddr_rd_en), .o_ddr_rd_ready(ddr_rd_ready), .o_ddr_rdata(ddr_rdata), .o_ddr_rvalid(ddr_rvalid),
    .o_count(count), .o_full(full), .o_empty(empty), .o_almost_full(almost_full),
    .o_almost_empty(almost_empty), .o_state(state), .o_err(err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer is just an ordered list of L1 words plus a direction lock.
  logic [L1_W-1:0]  mq[$];
  int               mst;
  logic [L1_W-1:0]  e_l1_rdata;
  logic [DDR_W-1:0] e_ddr_rdata;
  bit               e_l1_rvalid, e_ddr_rvalid, e_err, l1_zero, ddr_zero;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mst = 0;
    e_l1_rvalid = 0; e_ddr_rvalid = 0; e_err = 0;
    e_l1_rdata = '0; e_ddr_rdata = '0;
    l1_zero = 1; ddr_zero = 1;
  endtask

  function automatic bit rdy_dw(); return mst != 2 && mq.size() <= DEPTH - RATIO; endfunction
  function automatic bit rdy_lr(); return mst == 1 && mq.size() >= 1;             endfunction
  function automatic bit rdy_lw(); return mst != 1 && mq.size() < DEPTH;          endfunction
  function automatic bit rdy_dr(); return mst == 2 && mq.size() >= RATIO;         endfunction

  task automatic check_outputs();
    chk("count", count, mq.size());
    chk("state", state, mst);
    chk("full", full, mq.size() == DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("almost_full", almost_full, mq.size() >= AF);
    chk("almost_empty", almost_empty, mq.size() <= AE);
    chk("l1_rvalid", l1_rvalid, e_l1_rvalid);
    chk("ddr_rvalid", ddr_rvalid, e_ddr_rvalid);
    chk("err", err, e_err);
    if (e_l1_rvalid || l1_zero)   chk("l1_rdata", l1_rdata, e_l1_rdata);
    if (e_ddr_rvalid || ddr_zero) chk("ddr_rdata", ddr_rdata, e_ddr_rdata);
  endtask

  task automatic cycle(input bit dw, input logic [DDR_W-1:0] dd, input bit lw, input logic [L1_W-1:0] ld,
                       input bit lr, input bit dr, input bit fl);
    bit a_dw, a_lw, a_lr, a_dr;
    ddr_wr_en = dw; ddr_wdata = dd; l1_wr_en = lw; l1_wdata = ld;
    l1_rd_en = lr; ddr_rd_en = dr; flush = fl;
    chk("ddr_wr_ready", ddr_wr_ready, rdy_dw());
    chk("l1_rd_ready", l1_rd_ready, rdy_lr());
    chk("l1_wr_ready", l1_wr_ready, rdy_lw());
    chk("ddr_rd_ready", ddr_rd_ready, rdy_dr());
    a_dw = dw && rdy_dw();
    a_lw = lw && rdy_lw() && !(mst == 0 && dw);
    a_lr = lr && rdy_lr();
    a_dr = dr && rdy_dr();
    @(posedge clk); #1;
    ddr_wr_en = 0; l1_wr_en = 0; l1_rd_en = 0; ddr_rd_en = 0; flush = 0;
    if (fl) begin
      model_reset();
    end else begin
      e_err = (dw && !a_dw) || (lw && !a_lw) || (lr && !a_lr) || (dr && !a_dr);
      e_l1_rvalid = a_lr;
      e_ddr_rvalid = a_dr;
      if (a_lr) begin e_l1_rdata = mq.pop_front(); l1_zero = 0; end
      if (a_dr) begin
        for (int k = 0; k < RATIO; k++) e_ddr_rdata[k*L1_W +: L1_W] = mq.pop_front();
        ddr_zero = 0;
      end
      if (a_dw) for (int k = 0; k < RATIO; k++) mq.push_back(dd[k*L1_W +: L1_W]);
      if (a_lw) mq.push_back(ld);
      if (mst == 0) begin
        if (a_dw) mst = 1;
        else if (a_lw) mst = 2;
      end else if (mq.size() == 0) begin
        mst = 0;
      end
    end
    check_outputs();
  endtask

  task automatic ddr_write(input logic [DDR_W-1:0] d); cycle(1, d, 0, '0, 0, 0, 0); endtask
  task automatic l1_write(input logic [L1_W-1:0] d);   cycle(0, '0, 1, d, 0, 0, 0); endtask
  task automatic l1_read();                             cycle(0, '0, 0, '0, 1, 0, 0); endtask

  function automatic logic [DDR_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [DDR_W-1:0] line;

  initial begin
    flush = 0; l1_wr_en = 0; l1_rd_en = 0; ddr_wr_en = 0; ddr_rd_en = 0;
    l1_wdata = '0; ddr_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // FILL: one line of ascending words, read back word by word
    for (int k = 0; k < RATIO; k++) line[k*L1_W +: L1_W] = 16'(k);
    ddr_write(line);
    chk("fill_count", count, 8);
    for (int k = 0; k < RATIO; k++) l1_read();
    chk("fill_last_word", l1_rdata, 16'h0007);
    chk("fill_idle", state, 2'b00);

    // DRAIN: eight L1 words form one line
    for (int k = 0; k < RATIO; k++) l1_write(16'(16'hA0 + k));
    chk("drain_rd_ready", ddr_rd_ready, 1'b1);
    cycle(0, '0, 0, '0, 0, 1, 0);
    chk("drain_line", ddr_rdata, 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);

    // Full, overflow rejection, then multiple laps around the ring
    for (int i = 0; i < 4; i++) ddr_write(rand_line());
    chk("full_flag", full, 1'b1);
    chk("full_wr_ready", ddr_wr_ready, 1'b0);
    ddr_write(rand_line());
    chk("overflow_err", err, 1'b1);
    chk("overflow_count", count, 32);
    for (int i = 0; i < 3; i++) l1_read();
    for (int i = 0; i < 120; i++) cycle($urandom_range(0, 3) == 0, rand_line(), 0, '0, 1, 0, 0);
    for (int i = 0; i < 40; i++) if (mq.size() > 0) l1_read();
    chk("laps_empty", empty, 1'b1);

    // Same-cycle DDR write and L1 read in FILL
    ddr_write(rand_line());
    cycle(1, rand_line(), 0, '0, 1, 0, 0);
    chk("simul_count", count, 15);
    chk("simul_err", err, 1'b0);
    for (int i = 0; i < 15; i++) l1_read();

    // Direction lock, then flush mid-DRAIN
    ddr_write(rand_line());
    for (int i = 0; i < 5; i++) l1_read();
    l1_write(16'h1234);
    chk("lock_err", err, 1'b1);
    chk("lock_count", count, 3);
    for (int i = 0; i < 3; i++) l1_read();
    l1_write(16'h5678);
    chk("lock_drain", state, 2'b10);
    for (int i = 0; i < 4; i++) l1_write(16'($urandom));
    cycle(0, '0, 1, 16'h9999, 0, 0, 1);
    chk("flush_count", count, 0);
    chk("flush_idle", state, 2'b00);

    // Asynchronous reset in the middle of a FILL burst
    ddr_write(rand_line());
    l1_read(); l1_read();
    #1 rst_n = 0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    ddr_write(rand_line());
    l1_read();

    // Random traffic on every port with occasional flushes
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 1), rand_line(), $urandom_range(0, 1), 16'($urandom),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 63) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
